// File: rtl/led_breather_pkg.sv
// Shared types and defaults for the breathing-LED stage.
package led_breather_pkg;

    localparam int PWM_BITS_DEF   = 8;
    localparam int HOLD_STEPS_DEF = 16;
    localparam int PHASE_W        = 3;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_e;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and duty comparator with a registered output.
module led_pwm
#(
    parameter int PWM_BITS = 8
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                en,
    output logic                pwm_o
);

    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                pwm_r;

    // Counter wraps MAX->0 on its own; duty changes apply mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
            pwm_r     <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            pwm_r     <= en && (duty > pwm_cnt_r);
        end
    end

    assign pwm_o = pwm_r;

endmodule

// File: rtl/led_breather.sv
// Breathing-LED envelope FSM driving a PWM LED. Optional gamma curve on the
// duty path is selected with LED_BREATHER_GAMMA_EN.
module led_breather
    import led_breather_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int HOLD_STEPS = HOLD_STEPS_DEF
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_i,
    input  logic                en_i,
    output logic                led_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic [PHASE_W-1:0]  phase_o
);

    localparam int HC_W = $clog2(HOLD_STEPS + 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
    localparam logic [HC_W-1:0]     HOLD_LAST = HC_W'(HOLD_STEPS - 1);

    state_e              state_r;
    logic [PWM_BITS-1:0] level_r;
    logic [HC_W-1:0]     hold_cnt_r;
    logic [PWM_BITS-1:0] duty_s;
    logic                run_s;

    // Envelope FSM; a low enable overrides any step and parks in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            level_r    <= LVL_ZERO;
            hold_cnt_r <= {HC_W{1'b0}};
        end else if (!en_i) begin
            state_r    <= ST_IDLE;
            level_r    <= LVL_ZERO;
            hold_cnt_r <= {HC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_UP;
                end
                ST_UP: begin
                    if (step_i) begin
                        level_r <= level_r + LVL_ONE;
                        if (level_r == LVL_MAX - LVL_ONE) begin
                            state_r    <= ST_HOLD_HI;
                            hold_cnt_r <= {HC_W{1'b0}};
                        end
                    end
                end
                ST_HOLD_HI, ST_HOLD_LO: begin
                    if (step_i) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            hold_cnt_r <= {HC_W{1'b0}};
                            state_r    <= (state_r == ST_HOLD_HI) ? ST_DOWN : ST_UP;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HC_W'(1);
                        end
                    end
                end
                ST_DOWN: begin
                    if (step_i) begin
                        level_r <= level_r - LVL_ONE;
                        if (level_r == LVL_ONE) begin
                            state_r    <= ST_HOLD_LO;
                            hold_cnt_r <= {HC_W{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    level_r    <= LVL_ZERO;
                    hold_cnt_r <= {HC_W{1'b0}};
                end
            endcase
        end
    end

`ifdef LED_BREATHER_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq_s;

    // Squared level keeps the fade perceptually even; keep the top half.
    always_comb begin
        sq_s   = {LVL_ZERO, level_r} * {LVL_ZERO, level_r};
        duty_s = PWM_BITS'(sq_s >> PWM_BITS);
        run_s  = (state_r != ST_IDLE);
    end
`else
    // Linear mapping: duty follows level directly.
    always_comb begin
        duty_s = level_r;
        run_s  = (state_r != ST_IDLE);
    end
`endif

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_s),
        .en    (run_s),
        .pwm_o (led_o)
    );

    assign level_o = level_r;
    assign phase_o = state_r;

endmodule

// File: tb/tb_led_breather.sv
// Self-checking bench for led_breather: 4-bit/2-hold instance for the
// envelope and control cases, 8-bit instance for the duty-mapping case.
module tb_led_breather;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step, en;
    logic       led;
    logic [3:0] level;
    logic [2:0] phase;

    logic       step8, en8;
    logic       led8;
    logic [7:0] level8;
    logic [2:0] phase8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       step;
        logic       en;
        logic [3:0] exp_level;
        logic [2:0] exp_phase;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] level;
        logic [2:0] phase;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    led_breather #(.PWM_BITS(4), .HOLD_STEPS(2)) dut (
        .clk(clk), .rst_n(rst_n), .step_i(step), .en_i(en),
        .led_o(led), .level_o(level), .phase_o(phase)
    );

    led_breather #(.PWM_BITS(8), .HOLD_STEPS(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .step_i(step8), .en_i(en8),
        .led_o(led8), .level_o(level8), .phase_o(phase8)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, queue the expectation, compare after the edge.
    task automatic apply(input string name, input logic s, input logic e,
                         input logic [3:0] el, input logic [2:0] ep);
        exp_t x;
        step = s;
        en   = e;
        x.name = name; x.level = el; x.phase = ep;
        sb.push_back(x);
        tick();
        step = 1'b0;
        x = sb.pop_front();
        chk({x.name, ".level"}, int'(level), int'(x.level));
        chk({x.name, ".phase"}, int'(phase), int'(x.phase));
    endtask

    task automatic count_led(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (led) cnt++;
        end
    endtask

    initial begin
        int   cnt;
        int   bad;
        int   exp8;
        vec_t v;

        // Envelope table: enable, 15 up, 2 hold, 15 down, 2 hold.
        v.step = 1'b0; v.en = 1'b1; v.exp_level = 4'd0; v.exp_phase = 3'd1;
        vecs.push_back(v);
        v.step = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            v.exp_level = 4'(i);
            v.exp_phase = (i == 15) ? 3'd2 : 3'd1;
            vecs.push_back(v);
        end
        v.exp_level = 4'd15; v.exp_phase = 3'd2; vecs.push_back(v);
        v.exp_phase = 3'd3; vecs.push_back(v);
        for (int i = 14; i >= 0; i--) begin
            v.exp_level = 4'(i);
            v.exp_phase = (i == 0) ? 3'd4 : 3'd3;
            vecs.push_back(v);
        end
        v.exp_level = 4'd0; v.exp_phase = 3'd4; vecs.push_back(v);
        v.exp_phase = 3'd1; vecs.push_back(v);

        rst_n = 1'b0; step = 1'b0; en = 1'b0; step8 = 1'b0; en8 = 1'b0;
        tick(); tick();
        chk("reset.level", int'(level), 0);
        chk("reset.phase", int'(phase), 0);
        chk("reset.led", int'(led), 0);
        rst_n = 1'b1;

        // Scenario 1: reset asserted mid-ramp, released with enable low.
        apply("s1.en", 1'b0, 1'b1, 4'd0, 3'd1);
        apply("s1.up1", 1'b1, 1'b1, 4'd1, 3'd1);
        apply("s1.up2", 1'b1, 1'b1, 4'd2, 3'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s1.async.level", int'(level), 0);
        chk("s1.async.phase", int'(phase), 0);
        chk("s1.async.led", int'(led), 0);
        en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (level != 4'd0 || phase != 3'd0 || led != 1'b0) bad++;
        end
        chk("s1.idle100.bad_cycles", bad, 0);

        // Scenario 2: full envelope, one step every 20 cycles.
        foreach (vecs[k]) begin
            apply($sformatf("s2.v%0d", k), vecs[k].step, vecs[k].en,
                  vecs[k].exp_level, vecs[k].exp_phase);
            for (int j = 0; j < 19; j++) tick();
            chk($sformatf("s2.v%0d.stable_level", k), int'(level), int'(vecs[k].exp_level));
        end

        // Scenario 3: duty at levels 0, 5 and 15 (state UP, then HOLD_HI).
        count_led(32, cnt);
        chk("s3.duty0", cnt, 0);
        for (int i = 1; i <= 5; i++) apply("s3.up", 1'b1, 1'b1, 4'(i), 3'd1);
        tick();
        count_led(16, cnt);
        chk("s3.duty5", cnt, 5);
        count_led(16, cnt);
        chk("s3.duty5b", cnt, 5);
        for (int i = 6; i <= 15; i++)
            apply("s3.up", 1'b1, 1'b1, 4'(i), (i == 15) ? 3'd2 : 3'd1);
        tick();
        count_led(16, cnt);
        chk("s3.duty15", cnt, 15);

        // Scenario 4: drop enable at level 9 in DOWN, then re-enable with a step.
        apply("s4.hold1", 1'b1, 1'b1, 4'd15, 3'd2);
        apply("s4.hold2", 1'b1, 1'b1, 4'd15, 3'd3);
        for (int i = 14; i >= 9; i--) apply("s4.down", 1'b1, 1'b1, 4'(i), 3'd3);
        apply("s4.drop", 1'b0, 1'b0, 4'd0, 3'd0);
        tick();
        chk("s4.led_after_drop", int'(led), 0);
        count_led(16, cnt);
        chk("s4.led_off16", cnt, 0);
        apply("s4.reen_step_ignored", 1'b1, 1'b1, 4'd0, 3'd1);
        apply("s4.restart", 1'b1, 1'b1, 4'd1, 3'd1);

        // Scenario 5: step and enable-low on the same edge.
        apply("s5.step_and_drop", 1'b1, 1'b0, 4'd0, 3'd0);
        apply("s5.stay_idle", 1'b0, 1'b0, 4'd0, 3'd0);

        // Scenario 6: 8-bit instance at level 128 via a 128-cycle held step.
        en8 = 1'b1;
        tick();
        chk("s6.phase_up", int'(phase8), 1);
        step8 = 1'b1;
        for (int i = 0; i < 128; i++) tick();
        step8 = 1'b0;
        chk("s6.level128", int'(level8), 128);
        tick(); tick();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (led8) cnt++;
        end
`ifdef LED_BREATHER_GAMMA_EN
        exp8 = (128 * 128) / 256;
`else
        exp8 = 128;
`endif
        chk("s6.duty", cnt, exp8);
        chk("s6.level_held", int'(level8), 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
